// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// default widths and the two-way round-robin pick rule.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // A lone requester always wins; on a tie the port not granted last wins.
   function automatic logic rr2_pick(input logic [1:0] req, input logic last);
      rr2_pick = (req == 2'b11) ? ~last : req[1];
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// last-grant pointer and updates it only when valid is taken.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       enable,
   output logic       winner,
   output logic       valid
);

   assign valid  = enable & (|req);
   assign winner = rr2_pick(req, last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-client single-port memory arbiter: round-robin grant, one-cycle
// strobe, wait for the memory to go idle, then a one-cycle ack.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              c0_req,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_ack,
   output logic [DATA_W-1:0] c0_rdata,

   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_ack,
   output logic [DATA_W-1:0] c1_rdata,

   output logic              mem_rd_enable,
   output logic              mem_wr_enable,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_busy
);

   arb_state_e        state_q, state_d;
   logic              idx_q, idx_d;
   logic              we_q, we_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              arb_en;
   logic              grant_vld;
   logic              grant_idx;

   // External busy in IDLE holds off the grant entirely.
   assign arb_en = (state_q == ST_IDLE) && !mem_busy;

   mem_arb_rr2 u_rr2 (
      .req    ({c1_req, c0_req}),
      .last   (last_q),
      .enable (arb_en),
      .winner (grant_idx),
      .valid  (grant_vld)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we_d    = we_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               idx_d   = grant_idx;
               last_d  = grant_idx;
               we_d    = grant_idx ? c1_we    : c0_we;
               addr_d  = grant_idx ? c1_addr  : c0_addr;
               wdata_d = grant_idx ? c1_wdata : c0_wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!mem_busy) begin
               if (!we_q) rdata_d = mem_rd_data;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 1'b0;
         we_q    <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes and acks decode straight from the registered state.
   assign mem_rd_enable = (state_q == ST_ISSUE) && !we_q;
   assign mem_wr_enable = (state_q == ST_ISSUE) &&  we_q;
   assign mem_rd_addr   = addr_q;
   assign mem_wr_addr   = addr_q;
   assign mem_wr_data   = wdata_q;

   assign c0_ack   = (state_q == ST_DONE) && !idx_q;
   assign c1_ack   = (state_q == ST_DONE) &&  idx_q;
   assign c0_rdata = rdata_q;
   assign c1_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 5-cycle-busy memory model.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_req, c0_we, c1_req, c1_we;
   logic [AW-1:0] c0_addr, c1_addr;
   logic [DW-1:0] c0_wdata, c1_wdata;
   logic          c0_ack, c1_ack;
   logic [DW-1:0] c0_rdata, c1_rdata;
   logic          mem_rd_enable, mem_wr_enable;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
   logic [DW-1:0] mem_wr_data, mem_rd_data;
   logic          mem_busy;

   logic          force_busy;
   logic [2:0]    busy_cnt;
   logic [DW-1:0] mem [0:255];

   int            n_cmp;
   int            n_bad;
   int            dual_cnt;
   logic          rec_we;
   logic [AW-1:0] rec_addr;
   logic [DW-1:0] rec_data;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .c0_req        (c0_req),
      .c0_we         (c0_we),
      .c0_addr       (c0_addr),
      .c0_wdata      (c0_wdata),
      .c0_ack        (c0_ack),
      .c0_rdata      (c0_rdata),
      .c1_req        (c1_req),
      .c1_we         (c1_we),
      .c1_addr       (c1_addr),
      .c1_wdata      (c1_wdata),
      .c1_ack        (c1_ack),
      .c1_rdata      (c1_rdata),
      .mem_rd_enable (mem_rd_enable),
      .mem_wr_enable (mem_wr_enable),
      .mem_rd_addr   (mem_rd_addr),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_rd_data   (mem_rd_data),
      .mem_busy      (mem_busy)
   );

   // Memory model: busy for 5 cycles starting the cycle after a strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                busy_cnt <= 3'd0;
      else if (mem_rd_enable || mem_wr_enable) busy_cnt <= 3'd5;
      else if (busy_cnt != 3'd0)               busy_cnt <= busy_cnt - 3'd1;
   end
   assign mem_busy = (busy_cnt != 3'd0) || force_busy;

   always @(posedge clk) begin
      if (mem_wr_enable) mem[mem_wr_addr[7:0]] <= mem_wr_data;
      if (mem_rd_enable) mem_rd_data <= mem[mem_rd_addr[7:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One negedge sample: note double acks and the last memory strobe.
   task automatic tick();
      @(negedge clk);
      if (c0_ack && c1_ack) dual_cnt++;
      if (mem_wr_enable || mem_rd_enable) begin
         rec_we   = mem_wr_enable;
         rec_addr = mem_wr_enable ? mem_wr_addr : mem_rd_addr;
         rec_data = mem_wr_data;
      end
   endtask

   task automatic start(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      if (port == 0) begin c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d; end
      else           begin c1_req = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d; end
   endtask

   // n = negedges elapsed (0-based) until the port's ack; -1 on timeout.
   task automatic wait_ack(input int port, output int n);
      n = -1;
      for (int k = 0; k < 60; k++) begin
         tick();
         if ((port == 0 && c0_ack) || (port == 1 && c1_ack)) begin n = k; break; end
      end
   endtask

   task automatic wait_any(output int port, output int n);
      n = -1;
      port = -1;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (c0_ack || c1_ack) begin n = k; port = c1_ack ? 1 : 0; break; end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, p;
      int   grants [4];
      logic seen;

      n_cmp = 0; n_bad = 0; dual_cnt = 0;
      rec_we = 1'b0; rec_addr = '0; rec_data = '0;
      rst = 1'b0; force_busy = 1'b0;
      c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
      c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;

      repeat (3) tick();
      check("rst_c0_ack",   32'(c0_ack), 0);
      check("rst_c1_ack",   32'(c1_ack), 0);
      check("rst_rd_en",    32'(mem_rd_enable), 0);
      check("rst_wr_en",    32'(mem_wr_enable), 0);
      check("rst_c0_rdata", 32'(c0_rdata), 0);
      @(posedge clk); #1; rst = 1'b1;

      // V1: write then read back on port 0; a write must not touch rdata
      start(0, 1'b1, 16'h0012, 16'hBEEF);
      wait_ack(0, n);
      check("v1_wr_ack_cyc",  n, 8);
      check("v1_wr_rdata",    32'(c0_rdata), 0);
      check("v1_wr_strobe_we",32'(rec_we), 1);
      check("v1_wr_addr",     32'(rec_addr), 32'h12);
      check("v1_wr_data",     32'(rec_data), 32'hBEEF);
      c0_req = 0;
      start(0, 1'b0, 16'h0012, 16'h0000);
      wait_ack(0, n);
      check("v1_rd_ack_cyc",  n, 8);
      check("v1_rd_strobe_we",32'(rec_we), 0);
      check("v1_rd_c0_rdata", 32'(c0_rdata), 32'hBEEF);
      check("v1_rd_c1_rdata", 32'(c1_rdata), 32'hBEEF);
      c0_req = 0;
      start(1, 1'b1, 16'h0056, 16'h5A5A);
      wait_ack(1, n);
      check("v1_c1_wr_ack_cyc", n, 8);
      c1_req = 0;

      // V2: simultaneous reads right after reset -> port 0 first, port 1 nine cycles later
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      c0_req = 1; c0_we = 0; c0_addr = 16'h0012;
      c1_req = 1; c1_we = 0; c1_addr = 16'h0056;
      wait_ack(0, n);
      check("v2_c0_ack_cyc", n, 8);
      check("v2_c0_rdata",   32'(c0_rdata), 32'hBEEF);
      c0_req = 0;
      wait_ack(1, n);
      check("v2_c1_gap", n + 1, 9);
      check("v2_c1_rdata", 32'(c1_rdata), 32'h5A5A);
      c1_req = 0;

      // V3: both hold requests across four transactions -> strict alternation
      @(posedge clk); #1;
      c0_req = 1; c0_we = 0; c0_addr = 16'h0012;
      c1_req = 1; c1_we = 0; c1_addr = 16'h0056;
      for (int i = 0; i < 4; i++) begin
         wait_any(p, n);
         grants[i] = p;
         check("v3_period", n, 8);
      end
      c0_req = 0; c1_req = 0;
      check("v3_grant0", grants[0], 0);
      check("v3_grant1", grants[1], 1);
      check("v3_grant2", grants[2], 0);
      check("v3_grant3", grants[3], 1);

      // V4: external busy holds off the grant for 20 cycles
      @(posedge clk); #1;
      force_busy = 1; c1_req = 1; c1_we = 1; c1_addr = 16'h0020; c1_wdata = 16'h0F0F;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | mem_wr_enable | mem_rd_enable;
      end
      check("v4_no_strobe_busy", 32'(seen), 0);
      @(posedge clk); #1; force_busy = 0;
      tick();
      check("v4_idle_after_busy", 32'(mem_wr_enable), 0);
      tick();
      check("v4_issue_next", 32'(mem_wr_enable), 1);
      wait_ack(1, n);
      check("v4_ack_cyc", n, 6);
      c1_req = 0;

      // V5: request fields change after the grant
      start(0, 1'b1, 16'h0040, 16'h1234);
      @(posedge clk); #1; c0_addr = 16'h0000; c0_wdata = 16'h0000;
      wait_ack(0, n);
      check("v5_ack_cyc", n, 7);
      check("v5_mem_addr", 32'(rec_addr), 32'h40);
      check("v5_mem_data", 32'(rec_data), 32'h1234);
      c0_req = 0;
      start(0, 1'b0, 16'h0040, 16'h0000);
      wait_ack(0, n);
      check("v5_readback", 32'(c0_rdata), 32'h1234);
      c0_req = 0;

      // V6: reset during WAIT abandons the read
      start(0, 1'b0, 16'h0040, 16'h0000);
      repeat (4) tick();
      #1; rst = 1'b0; #1;
      check("v6_c0_ack",   32'(c0_ack), 0);
      check("v6_c1_ack",   32'(c1_ack), 0);
      check("v6_strobes",  32'(mem_rd_enable | mem_wr_enable), 0);
      check("v6_rdata",    32'(c0_rdata), 0);
      c0_req = 0;
      seen = 0;
      for (int i = 0; i < 3; i++) begin tick(); seen = seen | c0_ack | c1_ack; end
      @(posedge clk); #1; rst = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); seen = seen | c0_ack | c1_ack; end
      check("v6_no_ack_after_rst", 32'(seen), 0);
      start(1, 1'b0, 16'h0040, 16'h0000);
      wait_ack(1, n);
      check("v6_c1_ack_cyc", n, 8);
      check("v6_c1_rdata",   32'(c1_rdata), 32'h1234);
      c1_req = 0;

      check("no_dual_ack", dual_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: word address width.
REQ-002 SHALL have parameter DATA_W, default 16: data width.
REQ-003 SHALL have ports as follows:
  clk  input  1  single clock; all logic on rising edge.
  rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cN_req, cN_we, cN_addr, cN_wdata, cN_ack and cN_rdata for N = 0, 1:
  cN_req    input   1       request; held high until cN_ack.
  cN_we     input   1       1 = write, 0 = read.
  cN_addr   input   ADDR_W  word address.
  cN_wdata  input   DATA_W  write data.
  cN_ack    output  1       one-cycle completion pulse.
  cN_rdata  output  DATA_W  read data; valid while cN_ack = 1.
REQ-005 SHALL have memory-side ports:
  mem_rd_enable  output  1       one-cycle read strobe.
  mem_wr_enable  output  1       one-cycle write strobe.
  mem_rd_addr    output  ADDR_W  read address.
  mem_wr_addr    output  ADDR_W  write address.
  mem_wr_data    output  DATA_W  write data.
  mem_rd_data    input   DATA_W  memory read data.
  mem_busy       input   1       memory busy; rises the cycle after a strobe.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE, all registered.
REQ-007 IDLE: if any cN_req = 1 and mem_busy = 0, SHALL latch the winner's index, we, addr and wdata, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-008 Round-robin arbitration:
  - single requester wins.
  - both requesting: the port not granted last wins.
  - the last-grant pointer updates only on a grant.
REQ-009 ISSUE SHALL last exactly one cycle, during which:
  - mem_wr_enable = we, or mem_rd_enable = !we.
  - mem_rd_addr and mem_wr_addr both = latched addr.
  - mem_wr_data = latched wdata.
  It SHALL then go to WAIT.
REQ-010 WAIT SHALL stay while mem_busy = 1. On mem_busy = 0 it SHALL capture mem_rd_data into the rdata register (reads only) and go to DONE.
REQ-011 DONE SHALL last one cycle:
  - asserts only the granted cN_ack.
  - both cN_rdata show the rdata register.
  - returns to IDLE.
REQ-012 Outside ISSUE, the memory strobes SHALL be 0. Outside DONE, cN_ack SHALL be 0.
REQ-013 A write SHALL leave the rdata register unchanged.
REQ-014 Latency with a 5-cycle busy SHALL be: req sampled in cycle 0 -> ISSUE in cycle 1 -> WAIT in cycles 2-7 -> ack in cycle 8.
REQ-015 Back-to-back service SHALL pass through one IDLE cycle; minimum transaction period is 9 cycles.
REQ-016 Request fields changing after the grant SHALL NOT affect the transaction in flight.
REQ-017 Deassertion of cN_req after the grant SHALL NOT abort the transaction; ack is still issued.
REQ-018 mem_busy = 1 in IDLE (external busy) SHALL block the grant until it falls.
REQ-019 Simultaneous requests SHALL never both be acked in the same cycle.

Reset
REQ-020 rst = 0 SHALL asynchronously force:
  - state IDLE.
  - all strobes and acks 0.
  - addr, data and rdata registers 0.
  - last-grant pointer = 1, so port 0 wins first.
REQ-021 Reset during ISSUE, WAIT or DONE SHALL abandon the transaction with no ack. After release, the block SHALL resume in IDLE on the next rising edge.

Structure
REQ-022 The FSM state enum and the ADDR_W/DATA_W defaults SHALL live in shared package mem_arb_pkg.
REQ-023 The two-way round-robin picker SHALL be sub-module mem_arb_rr2: inputs req[1:0], last, enable; outputs winner and valid. Everything else SHALL be in mem_port_arbiter.

Verification
REQ-024 The bench SHALL drive memory with a model asserting busy for 5 cycles after each strobe, with 1-cycle rd_data. It SHALL cover these scenarios:
  - V1: c0 write addr 0x12, data 0xBEEF, then c0 read addr 0x12 -> c0_ack in cycle 8 of each; c0_rdata = 0xBEEF.
  - V2: c0 and c1 request reads in the same cycle after reset -> c0 acked first; c1 ack exactly 9 cycles later.
  - V3: c0 and c1 both hold requests continuously for 4 transactions -> grants alternate 0,1,0,1; never two acks in the same cycle.
  - V4: mem_busy forced high for 20 cycles while c1_req = 1 -> no strobe until busy falls; then ISSUE on the next cycle.
  - V5: c0 changes addr and wdata to 0x00 and 0x0000 one cycle after the grant -> memory sees the original values.
  - V6: rst pulled low during WAIT -> no ack; outputs 0. After release, c1 alone requesting is granted.
